// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider bank.
// Effective divisor clamps 0/1 to MIN_DIV; high phase gets the extra cycle on odd divisors.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned eff_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic int unsigned high_cnt(input int unsigned div);
    int unsigned d;
    d = eff_div(div);
    return d - (d / 2);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN FSM, period counter and double-buffered divisor.
// All outputs are registered; a new divisor only lands on a period boundary or a sync restart.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             run_o
);

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] h_cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic             last;

  assign d_eff   = DIV_W'(eff_div(32'(div_act_q)));
  assign h_cnt   = DIV_W'(high_cnt(32'(div_act_q)));
  assign cnt_inc = count_q + 1'b1;
  assign last    = (count_q == (d_eff - 1'b1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        clk_d   = 1'b0;
        if (load_i) begin
          div_act_d  = div_i;
          pend_vld_d = 1'b0;
        end
        if (en_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end

      RUN: begin
        // Sync restarts the period exactly like a boundary, but from any count.
        if (sync_i || last) begin
          count_d = '0;
          if (en_i) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
            if (pend_vld_q) begin
              div_act_d  = div_pend_q;
              pend_vld_d = 1'b0;
            end
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          count_d = cnt_inc;
          clk_d   = (cnt_inc < h_cnt);
        end

        if (load_i) begin
          if (sync_i) begin
            div_act_d  = div_i;
            pend_vld_d = 1'b0;
          end else begin
            div_pend_d = div_i;
            pend_vld_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      div_act_q  <= DIV_W'(DEFAULT_DIV);
      div_pend_q <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign run_o  = (state_q == RUN);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one reference clock.
// Channels interact only through the common sync_i restart.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       run_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i[n]),
      .load_i  (load_i[n]),
      .div_i   (div_i[n*DIV_W +: DIV_W]),
      .sync_i  (sync_i),
      .clk_o   (clk_o[n]),
      .tick_o  (tick_o[n]),
      .run_o   (run_o[n])
    );
  end

endmodule
